led_io_loader: RTL and testbench
================================

Name: led_io_loader

Overview:
- Byte-serial I/O front end for the LED cipher core inside tt_um_led_cipher.
- Collects a 64-bit key and a 64-bit plaintext from the 8-bit dedicated input pins using pin-driven strobes, then pulses the core start.
- Captures the 64-bit ciphertext when the core reports done and unloads it byte by byte onto the dedicated output pins.
- The key is retained between blocks, so later blocks need only new plaintext.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on each strobe input (minimum 2).
- BLOCK_BYTES, 8, bytes per key, plaintext and ciphertext (block width = 8*BLOCK_BYTES).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  design-selected enable; when low, all strobe events are ignored and state holds.
- data_in  input  8  byte from ui_in.
- wr_strobe  input  1  asynchronous write strobe from uio_in[0].
- sel_key  input  1  uio_in[1]: 1 routes the written byte to the key register, 0 to the plaintext register.
- rd_strobe  input  1  asynchronous read strobe from uio_in[2].
- data_out  output  8  byte to uo_out.
- busy  output  1  high in START and WAIT.
- ct_valid  output  1  high while ciphertext bytes remain to be read.
- overrun  output  1  sticky error flag.
- core_start  output  1  single-cycle start pulse to the cipher core.
- core_key  output  64  key register.
- core_pt  output  64  plaintext register.
- core_done  input  1  single-cycle completion pulse from the core.
- core_ct  input  64  ciphertext, valid when core_done is high.

Behaviour:
- Reset state, all asynchronous on rst_n low:
  - state = LOAD.
  - key, pt, ct registers, counters and synchronisers = 0.
  - data_out = 0; busy, ct_valid, overrun and core_start = 0.
- Strobes:
  - wr_strobe and rd_strobe each pass through SYNC_STAGES flops.
  - An event is a 0->1 edge on the synchronised signal, detected with one further flop.
  - Pin edge to event: SYNC_STAGES+1 cycles. An event is one cycle wide.
  - Events are masked while ena is low.
- LOAD:
  - On a wr event, shift MSB-first into the selected register: reg <= {reg[55:0], data_in}.
  - key_cnt and pt_cnt each count 0..8 and saturate at 8; extra bytes still shift, discarding the oldest byte.
  - rd events are ignored.
  - When key_cnt==8 and pt_cnt==8 at the end of a cycle, go to START next cycle.
- START:
  - core_start = 1 for exactly one cycle.
  - pt_cnt is cleared to 0; key_cnt is held, so the key is reused.
  - Go to WAIT.
- WAIT:
  - On core_done, ct <= core_ct, ct_valid = 1, rd_cnt = 0, go to UNLOAD.
  - core_done in any other state is ignored.
- UNLOAD:
  - data_out = ct[63:56] combinationally from the ct register.
  - On a rd event, ct <= {ct[55:0], 8'h00} and rd_cnt is incremented.
  - The event that brings rd_cnt to 8 clears ct_valid and returns to LOAD.
- Error handling:
  - Any wr event in START, WAIT or UNLOAD is ignored and sets overrun.
  - overrun clears only on reset.
  - A simultaneous wr and rd event in UNLOAD: the read is performed and overrun is set.
- busy = (state==START) or (state==WAIT).
- core_key and core_pt are driven straight from their registers and are stable from START until LOAD is re-entered. No writes are accepted in WAIT, so they cannot change while the core runs.
- ena deasserted mid-operation: the FSM still advances on core_done, since the core handshake is not masked; only strobe events are masked.
- data_out outside UNLOAD is 0, unless the optional feature is enabled.
- Reset asserted mid-operation returns to LOAD with all state cleared, including the key.

Optional Feature:
- Macro LED_LOADER_ECHO_EN.
- Defined: in LOAD, data_out shows the last byte accepted by a wr event (register, reset 0), so the host can read back for loopback checks. UNLOAD behaviour is unchanged.
- Undefined: data_out = 0 outside UNLOAD and no echo register exists.

Test Plan:
- Basic block:
  - Stimulus: reset; write key bytes 01 23 45 67 89 AB CD EF (sel_key=1) and plaintext bytes 00 11 22 33 44 55 66 77 (sel_key=0). Stub core asserts done 4 cycles after start with ct = pt^key.
  - Response: core_key=0x0123456789ABCDEF, core_pt=0x0011223344556677, exactly one core_start pulse; eight reads return 01 32 67 54 CD FE AB 98; ct_valid drops after the 8th read.
- Key reuse:
  - Stimulus: after the first block, write only 8 plaintext bytes FF.
  - Response: core_start pulses with core_key unchanged; ciphertext reads FE DC BA 98 76 54 32 10.
- Overflow shift:
  - Stimulus: write 9 plaintext bytes 00..08.
  - Response: core_pt=0x0102030405060708; no start until the key is also complete.
- Overrun:
  - Stimulus: a wr event during WAIT.
  - Response: overrun=1, core_pt unchanged, overrun persists through UNLOAD and back into LOAD.
- Masking and synchroniser latency:
  - Stimulus: strobes toggled with ena=0.
  - Response: no counter change.
  - Stimulus: with ena=1, a wr_strobe edge.
  - Response: the shift occurs exactly SYNC_STAGES+1 cycles later.
- Reset mid-UNLOAD:
  - Stimulus: assert rst_n low after 3 reads.
  - Response: data_out=0, ct_valid=0, state LOAD, key_cnt=0, so a fresh key is required.

Source files
------------

// File: rtl/led_io_loader.sv
// Byte-serial key/plaintext loader and ciphertext unloader for the LED cipher core.
// Optional read-back of the last written byte in LOAD: define LED_LOADER_ECHO_EN.
module led_io_loader #(
  parameter int SYNC_STAGES = 2,
  parameter int BLOCK_BYTES = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic [7:0]               data_in,
  input  logic                     wr_strobe,
  input  logic                     sel_key,
  input  logic                     rd_strobe,
  output logic [7:0]               data_out,
  output logic                     busy,
  output logic                     ct_valid,
  output logic                     overrun,
  output logic                     core_start,
  output logic [8*BLOCK_BYTES-1:0] core_key,
  output logic [8*BLOCK_BYTES-1:0] core_pt,
  input  logic                     core_done,
  input  logic [8*BLOCK_BYTES-1:0] core_ct
);

  localparam int W  = 8 * BLOCK_BYTES;
  localparam int CW = $clog2(BLOCK_BYTES + 1);
  localparam logic [CW-1:0] FULL = CW'(BLOCK_BYTES);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    UNLOAD = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [W-1:0]        key_r, key_s, pt_r, pt_s, ct_r, ct_s;
  logic [CW-1:0]       key_cnt_r, key_cnt_s, pt_cnt_r, pt_cnt_s, rd_cnt_r, rd_cnt_s;
  logic                ct_valid_r, ct_valid_s, overrun_r, overrun_s;
  logic [SYNC_STAGES-1:0] wr_sync_r, rd_sync_r;
  logic                wr_prev_r, rd_prev_r;
  logic                wr_ev_s, rd_ev_s;

  // Strobe synchronisers plus one edge-detect flop each.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sync_r <= '0;
      rd_sync_r <= '0;
      wr_prev_r <= 1'b0;
      rd_prev_r <= 1'b0;
    end else begin
      wr_sync_r <= {wr_sync_r[SYNC_STAGES-2:0], wr_strobe};
      rd_sync_r <= {rd_sync_r[SYNC_STAGES-2:0], rd_strobe};
      wr_prev_r <= wr_sync_r[SYNC_STAGES-1];
      rd_prev_r <= rd_sync_r[SYNC_STAGES-1];
    end
  end

  assign wr_ev_s = ena & wr_sync_r[SYNC_STAGES-1] & ~wr_prev_r;
  assign rd_ev_s = ena & rd_sync_r[SYNC_STAGES-1] & ~rd_prev_r;

  // Next-state and datapath update for the load/start/wait/unload sequence.
  always_comb begin
    state_s    = state_r;
    key_s      = key_r;
    pt_s       = pt_r;
    ct_s       = ct_r;
    key_cnt_s  = key_cnt_r;
    pt_cnt_s   = pt_cnt_r;
    rd_cnt_s   = rd_cnt_r;
    ct_valid_s = ct_valid_r;
    // Writes outside LOAD are dropped but flagged; the flag is sticky.
    overrun_s  = overrun_r | (wr_ev_s & (state_r != LOAD));
    case (state_r)
      LOAD: begin
        if (wr_ev_s && sel_key) begin
          key_s     = {key_r[W-9:0], data_in};
          key_cnt_s = (key_cnt_r == FULL) ? key_cnt_r : key_cnt_r + CW'(1);
        end else if (wr_ev_s) begin
          pt_s      = {pt_r[W-9:0], data_in};
          pt_cnt_s  = (pt_cnt_r == FULL) ? pt_cnt_r : pt_cnt_r + CW'(1);
        end else begin
          key_s = key_r;
        end
        if (key_cnt_r == FULL && pt_cnt_r == FULL) begin
          state_s = START;
        end else begin
          state_s = LOAD;
        end
      end
      START: begin
        pt_cnt_s = '0;
        state_s  = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          ct_s       = core_ct;
          ct_valid_s = 1'b1;
          rd_cnt_s   = '0;
          state_s    = UNLOAD;
        end else begin
          state_s = WAIT;
        end
      end
      UNLOAD: begin
        if (rd_ev_s) begin
          ct_s     = {ct_r[W-9:0], 8'h00};
          rd_cnt_s = rd_cnt_r + CW'(1);
          if (rd_cnt_r == FULL - CW'(1)) begin
            ct_valid_s = 1'b0;
            state_s    = LOAD;
          end else begin
            state_s = UNLOAD;
          end
        end else begin
          state_s = UNLOAD;
        end
      end
      default: begin
        state_s = LOAD;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= LOAD;
      key_r      <= '0;
      pt_r       <= '0;
      ct_r       <= '0;
      key_cnt_r  <= '0;
      pt_cnt_r   <= '0;
      rd_cnt_r   <= '0;
      ct_valid_r <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      key_r      <= key_s;
      pt_r       <= pt_s;
      ct_r       <= ct_s;
      key_cnt_r  <= key_cnt_s;
      pt_cnt_r   <= pt_cnt_s;
      rd_cnt_r   <= rd_cnt_s;
      ct_valid_r <= ct_valid_s;
      overrun_r  <= overrun_s;
    end
  end

`ifdef LED_LOADER_ECHO_EN
  logic [7:0] echo_r;

  // Last byte accepted in LOAD, for host loopback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_r <= 8'h00;
    end else if (wr_ev_s && state_r == LOAD) begin
      echo_r <= data_in;
    end else begin
      echo_r <= echo_r;
    end
  end
`endif

  // Output byte mux: ciphertext head in UNLOAD.
  always_comb begin
    data_out = 8'h00;
    if (state_r == UNLOAD) begin
      data_out = ct_r[W-1 -: 8];
    end
`ifdef LED_LOADER_ECHO_EN
    else if (state_r == LOAD) begin
      data_out = echo_r;
    end
`endif
    else begin
      data_out = 8'h00;
    end
  end

  assign busy       = (state_r == START) || (state_r == WAIT);
  assign core_start = (state_r == START);
  assign ct_valid   = ct_valid_r;
  assign overrun    = overrun_r;
  assign core_key   = key_r;
  assign core_pt    = pt_r;

endmodule

// File: tb/tb_led_io_loader.sv
// Scoreboard bench for led_io_loader with a stub cipher core (ct = pt ^ key).
module tb_led_io_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic [7:0]  data_in = 8'h00;
  logic        wr_strobe = 1'b0;
  logic        sel_key = 1'b0;
  logic        rd_strobe = 1'b0;
  logic [7:0]  data_out;
  logic        busy, ct_valid, overrun, core_start;
  logic [63:0] core_key, core_pt;
  logic        core_done = 1'b0;
  logic [63:0] core_ct = 64'h0;

  int n_cmp = 0;
  int n_err = 0;
  int start_cnt = 0;
  int done_delay = 4;
  int saved_starts;
  logic [7:0] sb[$];
  logic [63:0] key_bytes;

  led_io_loader #(.SYNC_STAGES(2), .BLOCK_BYTES(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data_in),
    .wr_strobe(wr_strobe), .sel_key(sel_key), .rd_strobe(rd_strobe),
    .data_out(data_out), .busy(busy), .ct_valid(ct_valid), .overrun(overrun),
    .core_start(core_start), .core_key(core_key), .core_pt(core_pt),
    .core_done(core_done), .core_ct(core_ct)
  );

  always #5 clk = ~clk;

  // Stub core: done (with ct = pt ^ key) done_delay cycles after start.
  always begin
    @(negedge clk);
    if (core_start) begin
      start_cnt++;
      repeat (done_delay - 1) @(negedge clk);
      core_ct   = core_pt ^ core_key;
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_ct(input logic [63:0] v);
    for (int i = 7; i >= 0; i--) sb.push_back(v[i*8 +: 8]);
  endtask

  task automatic wr_byte(input logic sk, input logic [7:0] d);
    @(negedge clk);
    data_in = d;
    sel_key = sk;
    wr_strobe = 1'b1;
    repeat (5) @(negedge clk);
    wr_strobe = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic rd_byte(input string tag);
    @(negedge clk);
    if (sb.size() == 0) chk("sb_empty", 64'd1, 64'd0);
    else chk(tag, {56'h0, data_out}, {56'h0, sb.pop_front()});
    rd_strobe = 1'b1;
    repeat (5) @(negedge clk);
    rd_strobe = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic write_block(input logic sk, input logic [63:0] v);
    for (int i = 7; i >= 0; i--) wr_byte(sk, v[i*8 +: 8]);
  endtask

  task automatic wait_ct_valid(input string tag);
    int n;
    n = 0;
    while (ct_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk(tag, 64'd0, 64'd1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
  endtask

  initial begin
    key_bytes = 64'h0123456789ABCDEF;
    repeat (3) @(negedge clk);
    // Reset state
    chk("rst_dout", {56'h0, data_out}, 64'h0);
    chk("rst_flags", {60'h0, busy, ct_valid, overrun, core_start}, 64'h0);
    chk("rst_key", core_key, 64'h0);
    chk("rst_pt", core_pt, 64'h0);
    rst_n = 1'b1;

    // Basic block
    write_block(1'b1, key_bytes);
    write_block(1'b0, 64'h0011223344556677);
    chk("basic_key", core_key, 64'h0123456789ABCDEF);
    chk("basic_pt", core_pt, 64'h0011223344556677);
    push_ct(64'h01326754CDFEAB98);
    wait_ct_valid("basic_timeout");
    chk("basic_starts", 64'(start_cnt), 64'd1);
    for (int i = 0; i < 8; i++) rd_byte("basic_rd");
    chk("basic_ctv_low", {63'h0, ct_valid}, 64'h0);

    // Key reuse with a write landing in WAIT
    done_delay = 30;
    write_block(1'b0, 64'hFFFFFFFFFFFFFFFF);
    chk("reuse_busy", {63'h0, busy}, 64'h1);
    wr_byte(1'b0, 8'h55);
    chk("ovr_set", {63'h0, overrun}, 64'h1);
    chk("ovr_pt_hold", core_pt, 64'hFFFFFFFFFFFFFFFF);
    chk("reuse_key", core_key, key_bytes);
    push_ct(64'hFEDCBA9876543210);
    wait_ct_valid("reuse_timeout");
    chk("reuse_starts", 64'(start_cnt), 64'd2);
    for (int i = 0; i < 8; i++) rd_byte("reuse_rd");
    chk("ovr_sticky", {63'h0, overrun}, 64'h1);
    done_delay = 4;

    // Reset mid-UNLOAD after three reads
    write_block(1'b0, 64'h0);
    push_ct(key_bytes);
    wait_ct_valid("mid_timeout");
    for (int i = 0; i < 3; i++) rd_byte("mid_rd");
    sb.delete();
    pulse_reset();
    chk("mid_dout", {56'h0, data_out}, 64'h0);
    chk("mid_ctv", {63'h0, ct_valid}, 64'h0);
    chk("mid_ovr", {63'h0, overrun}, 64'h0);
    chk("mid_key", core_key, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Masked strobes
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_byte(1'b0, 8'hAA);
      wr_byte(1'b1, 8'hBB);
    end
    ena = 1'b1;
    chk("mask_pt", core_pt, 64'h0);
    chk("mask_key", core_key, 64'h0);

    // Synchroniser latency: shift lands on the third edge after the pin edge
    @(negedge clk);
    data_in = 8'h5A;
    sel_key = 1'b0;
    wr_strobe = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      #1;
      chk("lat_pt", core_pt, (e == 3) ? 64'h5A : 64'h0);
    end
    repeat (3) @(negedge clk);
    wr_strobe = 1'b0;
    repeat (5) @(negedge clk);

    // Overflow shift: nine plaintext bytes, no start without a key
    pulse_reset();
    @(negedge clk);
    rst_n = 1'b1;
    saved_starts = start_cnt;
    for (int i = 0; i < 9; i++) wr_byte(1'b0, 8'(i));
    repeat (10) @(negedge clk);
    chk("ovf_pt", core_pt, 64'h0102030405060708);
    chk("ovf_nostart", 64'(start_cnt), 64'(saved_starts));
    chk("ovf_busy", {63'h0, busy}, 64'h0);
    write_block(1'b1, key_bytes);
    push_ct(64'h0102030405060708 ^ key_bytes);
    wait_ct_valid("ovf_timeout");
    chk("ovf_starts", 64'(start_cnt), 64'(saved_starts + 1));
    for (int i = 0; i < 8; i++) rd_byte("ovf_rd");
    chk("ovf_ctv_low", {63'h0, ct_valid}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
